// File: rtl/arith_pkg.sv
// Shared arithmetic helpers for the carry-select adder family.
// Provides opcode encodings, block-count math and the saturation clamp patterns.
package arith_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Saturation patterns are built at this width and truncated by the user.
   // This limits WIDTH to at most 64 bits.
   localparam int SAT_MAX_W = 64;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   // neg = 1 gives the most negative value {1,0..0}.
   // neg = 0 gives the most positive value {0,1..1}.
   function automatic logic [SAT_MAX_W-1:0] sat_pattern(input int width, input logic neg);
      logic [SAT_MAX_W-1:0] msb;
      msb = SAT_MAX_W'(1) << (width - 1);
      return neg ? msb : msb - SAT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/csel_block.sv
// Dual ripple-carry block: produces the sum and carry for both possible carry-ins at once.
module csel_block #(
   parameter int W = 5
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] s0,
   output logic         c0,
   output logic [W-1:0] s1,
   output logic         c1
);

   assign {c0, s0} = {1'b0, a} + {1'b0, b};
   assign {c1, s1} = {1'b0, a} + {1'b0, b} + (W+1)'(1);

endmodule

// File: rtl/csel_adder_pipe.sv
// Two-stage pipelined signed carry-select adder/subtractor with a valid/ready stream interface.
// Stage 1 does the per-block speculative adds; stage 2 resolves the carry-select chain and saturation.
module csel_adder_pipe
   import arith_pkg::*;
#(
   parameter int WIDTH = 25,
   parameter int BLK   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_op,
   input  logic             in_sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_ovf,
   output logic             out_cout
);

   localparam int NBLK = ceil_div(WIDTH, BLK);
   localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pattern(WIDTH, 1'b0));
   localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_pattern(WIDTH, 1'b1));

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] st_sum0;
   logic [WIDTH-1:0] st_sum1;
   logic [NBLK-1:0]  st_c0;
   logic [NBLK-1:0]  st_c1;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_sum0;
   logic [WIDTH-1:0] s1_sum1;
   logic [NBLK-1:0]  s1_c0;
   logic [NBLK-1:0]  s1_c1;
   logic             s1_a_msb;
   logic             s1_b_msb;
   logic             s1_sat;

   logic             s2_adv;
   logic             s1_load;
   logic [NBLK-1:0]  blk_cin;
   logic [WIDTH-1:0] raw_sum;
   logic             raw_cout;
   logic             raw_ovf;
   logic [WIDTH-1:0] res_sum;

   assign b_eff = (in_op == OP_SUB) ? ~in_b : in_b;

   genvar k;
   generate
      for (k = 0; k < NBLK; k++) begin : g_blk
         localparam int LO = k * BLK;
         localparam int BW = (k == NBLK - 1) ? WIDTH - LO : BLK;

         logic [BW-1:0] bs0;
         logic [BW-1:0] bs1;
         logic          bc0;
         logic          bc1;

         csel_block #(.W(BW)) u_blk (
            .a  (in_a[LO +: BW]),
            .b  (b_eff[LO +: BW]),
            .s0 (bs0),
            .c0 (bc0),
            .s1 (bs1),
            .c1 (bc1)
         );

         // Block 0 sees the true carry-in (in_op), so both speculative lanes hold the resolved result.
         if (k == 0) begin : g_first
            assign st_sum0[LO +: BW] = (in_op == OP_ADD) ? bs0 : bs1;
            assign st_sum1[LO +: BW] = (in_op == OP_ADD) ? bs0 : bs1;
            assign st_c0[k]          = (in_op == OP_ADD) ? bc0 : bc1;
            assign st_c1[k]          = (in_op == OP_ADD) ? bc0 : bc1;
         end else begin : g_rest
            assign st_sum0[LO +: BW] = bs0;
            assign st_sum1[LO +: BW] = bs1;
            assign st_c0[k]          = bc0;
            assign st_c1[k]          = bc1;
         end
      end
   endgenerate

   // Bubble-collapsing handshake: stage 1 may refill whenever its beat can move on.
   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;
   assign s1_load  = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sum0  <= '0;
         s1_sum1  <= '0;
         s1_c0    <= '0;
         s1_c1    <= '0;
         s1_a_msb <= 1'b0;
         s1_b_msb <= 1'b0;
         s1_sat   <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
         s1_sum0  <= st_sum0;
         s1_sum1  <= st_sum1;
         s1_c0    <= st_c0;
         s1_c1    <= st_c1;
         s1_a_msb <= in_a[WIDTH-1];
         s1_b_msb <= b_eff[WIDTH-1];
         s1_sat   <= in_sat;
      end else if (s2_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // Serial select chain; block 0 is entered with carry 0 so it always takes its resolved lane.
   always_comb begin
      logic carry;
      carry   = 1'b0;
      blk_cin = '0;
      for (int n = 0; n < NBLK; n++) begin
         blk_cin[n] = carry;
         carry      = carry ? s1_c1[n] : s1_c0[n];
      end
      raw_cout = carry;
      raw_sum  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         raw_sum[i] = blk_cin[i / BLK] ? s1_sum1[i] : s1_sum0[i];
      end
   end

   assign raw_ovf = (s1_a_msb == s1_b_msb) && (raw_sum[WIDTH-1] != s1_a_msb);
   assign res_sum = (s1_sat && raw_ovf) ? (s1_a_msb ? SAT_NEG : SAT_POS) : raw_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
         out_cout  <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_sum  <= res_sum;
            out_ovf  <= raw_ovf;
            out_cout <= raw_cout;
         end
      end
   end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Bench for csel_adder_pipe: directed corner cases, backpressure, reset and random runs on three configurations.
module tb_csel_adder_pipe;

   typedef struct {
      longint sum;
      bit     ovf;
      bit     cout;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        m_in_valid, m_in_ready, m_in_op, m_in_sat;
   logic        m_out_valid, m_out_ready, m_out_ovf, m_out_cout;
   logic [24:0] m_in_a, m_in_b, m_out_sum;

   logic        r_in_valid, r_out_ready;
   logic        r16_in_ready, r16_in_op, r16_in_sat, r16_out_valid, r16_out_ovf, r16_out_cout;
   logic [15:0] r16_in_a, r16_in_b, r16_out_sum;
   logic        r8_in_ready, r8_in_op, r8_in_sat, r8_out_valid, r8_out_ovf, r8_out_cout;
   logic [7:0]  r8_in_a, r8_in_b, r8_out_sum;

   int passed = 0;
   int total  = 0;

   exp_t q25[$];
   exp_t q16[$];
   exp_t q8[$];

   csel_adder_pipe #(.WIDTH(25), .BLK(5)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(m_in_valid), .in_ready(m_in_ready),
      .in_a(m_in_a), .in_b(m_in_b), .in_op(m_in_op), .in_sat(m_in_sat),
      .out_valid(m_out_valid), .out_ready(m_out_ready),
      .out_sum(m_out_sum), .out_ovf(m_out_ovf), .out_cout(m_out_cout)
   );

   csel_adder_pipe #(.WIDTH(16), .BLK(5)) u_dut16 (
      .clk(clk), .rst(rst),
      .in_valid(r_in_valid), .in_ready(r16_in_ready),
      .in_a(r16_in_a), .in_b(r16_in_b), .in_op(r16_in_op), .in_sat(r16_in_sat),
      .out_valid(r16_out_valid), .out_ready(r_out_ready),
      .out_sum(r16_out_sum), .out_ovf(r16_out_ovf), .out_cout(r16_out_cout)
   );

   csel_adder_pipe #(.WIDTH(8), .BLK(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(r_in_valid), .in_ready(r8_in_ready),
      .in_a(r8_in_a), .in_b(r8_in_b), .in_op(r8_in_op), .in_sat(r8_in_sat),
      .out_valid(r8_out_valid), .out_ready(r_out_ready),
      .out_sum(r8_out_sum), .out_ovf(r8_out_ovf), .out_cout(r8_out_cout)
   );

   // Golden model: signed arithmetic on wide integers, then wrap and clamp.
   function automatic exp_t model(input int w, input longint ua, input longint ub,
                                  input bit op, input bit sat);
      exp_t   e;
      longint one = 1;
      longint mx  = (one << (w - 1)) - 1;
      longint mn  = -(one << (w - 1));
      longint sa  = (ua > mx) ? ua - (one << w) : ua;
      longint sb  = (ub > mx) ? ub - (one << w) : ub;
      longint r   = op ? sa - sb : sa + sb;
      e.ovf  = (r > mx) || (r < mn);
      e.cout = op ? (ua >= ub) : (((ua + ub) >> w) != 0);
      if (e.ovf && sat) r = (r > mx) ? mx : mn;
      e.sum  = r & ((one << w) - 1);
      return e;
   endfunction

   function automatic longint rand_operand(input int w);
      longint one  = 1;
      longint mask = (one << w) - 1;
      int     sel  = $urandom_range(0, 7);
      case (sel)
         0:       return one << (w - 1);
         1:       return (one << (w - 1)) - 1;
         2:       return 0;
         3:       return mask;
         default: return longint'($urandom) & mask;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [24:0] a, input logic [24:0] b,
                                 input logic op, input logic sat);
      m_in_valid = 1'b1;
      m_in_a     = a;
      m_in_b     = b;
      m_in_op    = op;
      m_in_sat   = sat;
   endtask

   // Scoreboard step for one DUT: record an accepted beat, compare a popped one.
   task automatic check_output(input int idx, input int w, input bit acc,
                               input longint a, input longint b, input bit op, input bit sat,
                               input bit pop, input logic [63:0] sum, input bit ovf,
                               input bit cout, input string tag);
      exp_t e;
      int   n;
      n = (idx == 0) ? q25.size() : (idx == 1) ? q16.size() : q8.size();
      if (pop) begin
         if (n == 0) begin
            check({tag, "_spurious"}, 64'(n), 64'd1);
         end else begin
            case (idx)
               0:       e = q25.pop_front();
               1:       e = q16.pop_front();
               default: e = q8.pop_front();
            endcase
            check({tag, "_sum"}, sum, e.sum);
            check({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
            check({tag, "_cout"}, 64'(cout), 64'(e.cout));
         end
      end
      if (acc) begin
         e = model(w, a, b, op, sat);
         case (idx)
            0:       q25.push_back(e);
            1:       q16.push_back(e);
            default: q8.push_back(e);
         endcase
      end
   endtask

   logic [24:0] dir_a    [6] = '{25'd100, 25'h0FFFFFF, 25'h0FFFFFF, 25'h1000000, 25'h1000000, 25'd5};
   logic [24:0] dir_b    [6] = '{25'h1FFFFE2, 25'd1, 25'd1, 25'd1, 25'd1, 25'd5};
   logic        dir_op   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic        dir_sat  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [24:0] dir_sum  [6] = '{25'd70, 25'h1000000, 25'h0FFFFFF, 25'h0FFFFFF, 25'h1000000, 25'd0};
   logic        dir_ovf  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic        dir_cout [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   int          acc, pops, occ, cyc, last_pop;
   bit          stalled, do_acc, do_pop;
   logic [24:0] held;
   longint      ma, mb, a16, b16, a8, b8;

   initial begin
      rst = 1'b1;
      m_in_valid = 1'b0; m_in_a = '0; m_in_b = '0; m_in_op = 1'b0; m_in_sat = 1'b0;
      m_out_ready = 1'b1;
      r_in_valid = 1'b0; r_out_ready = 1'b1;
      r16_in_a = '0; r16_in_b = '0; r16_in_op = 1'b0; r16_in_sat = 1'b0;
      r8_in_a = '0; r8_in_b = '0; r8_in_op = 1'b0; r8_in_sat = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst_out_valid", 64'(m_out_valid), 64'd0);
      check("rst_out_sum", 64'(m_out_sum), 64'd0);
      check("rst_out_ovf", 64'(m_out_ovf), 64'd0);
      check("rst_out_cout", 64'(m_out_cout), 64'd0);
      check("rst_in_ready", 64'(m_in_ready), 64'd1);
      check("rst_r16_valid", 64'(r16_out_valid), 64'd0);
      check("rst_r8_valid", 64'(r8_out_valid), 64'd0);

      // Directed corners: result must appear exactly two cycles after the beat is presented.
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(dir_a[i], dir_b[i], dir_op[i], dir_sat[i]);
         #1;
         check("dir_in_ready", 64'(m_in_ready), 64'd1);
         @(posedge clk);
         #1 m_in_valid = 1'b0;
         #1;
         check("dir_lat1_valid", 64'(m_out_valid), 64'd0);
         @(posedge clk);
         #2;
         check("dir_lat2_valid", 64'(m_out_valid), 64'd1);
         check("dir_sum", 64'(m_out_sum), 64'(dir_sum[i]));
         check("dir_ovf", 64'(m_out_ovf), 64'(dir_ovf[i]));
         check("dir_cout", 64'(m_out_cout), 64'(dir_cout[i]));
      end

      // Backpressure: 20 beats a=i, b=2i under random out_ready.
      tick();
      acc = 0; pops = 0; occ = 0; cyc = 0; stalled = 1'b0; held = '0;
      while (pops < 20 && cyc < 400) begin
         if (stalled) begin
            check("bp_hold_valid", 64'(m_out_valid), 64'd1);
            check("bp_hold_sum", 64'(m_out_sum), 64'(held));
         end
         m_out_ready = 1'($urandom_range(0, 1));
         apply_stimulus(25'(acc), 25'(2 * acc), 1'b0, 1'b0);
         m_in_valid = (acc < 20);
         #1;
         check("bp_in_ready", 64'(m_in_ready), 64'(!(occ == 2 && !m_out_ready)));
         do_acc = m_in_valid && m_in_ready;
         do_pop = m_out_valid && m_out_ready;
         if (do_pop) begin
            check("bp_sum", 64'(m_out_sum), 64'(3 * pops));
            pops++;
         end
         stalled = m_out_valid && !m_out_ready;
         held    = m_out_sum;
         occ     = occ + int'(do_acc) - int'(do_pop);
         if (do_acc) acc++;
         tick();
         cyc++;
      end
      check("bp_count", 64'(pops), 64'd20);
      check("bp_accepted", 64'(acc), 64'd20);

      // Full throughput: beats presented in cycles 0..19, last result visible in cycle 21.
      m_out_ready = 1'b1;
      acc = 0; pops = 0; cyc = 0; last_pop = -1;
      while (pops < 20 && cyc < 100) begin
         apply_stimulus(25'(1000 * acc), 25'(-acc), 1'b0, 1'b0);
         m_in_valid = (acc < 20);
         #1;
         if (m_in_valid && m_in_ready) acc++;
         if (m_out_valid) begin
            check("tp_sum", 64'(m_out_sum), 64'(999 * pops));
            pops++;
            last_pop = cyc;
         end
         tick();
         cyc++;
      end
      check("tp_count", 64'(pops), 64'd20);
      check("tp_cycles", 64'(last_pop), 64'd21);

      // Reset with both stages full discards everything in flight.
      m_out_ready = 1'b0;
      apply_stimulus(25'd11, 25'd22, 1'b0, 1'b0);
      tick();
      apply_stimulus(25'd33, 25'd44, 1'b0, 1'b0);
      tick();
      #1;
      check("full_out_valid", 64'(m_out_valid), 64'd1);
      check("full_in_ready", 64'(m_in_ready), 64'd0);
      rst = 1'b1;
      apply_stimulus(25'd55, 25'd66, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      check("mid_rst_valid", 64'(m_out_valid), 64'd0);
      check("mid_rst_sum", 64'(m_out_sum), 64'd0);
      check("mid_rst_ovf", 64'(m_out_ovf), 64'd0);
      check("mid_rst_cout", 64'(m_out_cout), 64'd0);
      check("mid_rst_in_ready", 64'(m_in_ready), 64'd1);
      m_out_ready = 1'b1;
      apply_stimulus(25'h1FFFFF9, 25'd3, 1'b0, 1'b0);
      tick();
      m_in_valid = 1'b0;
      #1;
      check("post_rst_lat1", 64'(m_out_valid), 64'd0);
      tick();
      #1;
      check("post_rst_lat2", 64'(m_out_valid), 64'd1);
      check("post_rst_sum", 64'(m_out_sum), 64'h1FFFFFC);
      check("post_rst_cout", 64'(m_out_cout), 64'd0);
      tick();
      #1;
      check("post_rst_drain", 64'(m_out_valid), 64'd0);

      // Random run on all three configurations against the golden model.
      for (int c = 0; c < 11500; c++) begin
         r_in_valid  = ($urandom_range(0, 7) != 0);
         r_out_ready = ($urandom_range(0, 3) != 0);
         a16 = rand_operand(16); b16 = rand_operand(16);
         a8  = rand_operand(8);  b8  = rand_operand(8);
         ma  = rand_operand(25); mb  = rand_operand(25);
         r16_in_a = 16'(a16); r16_in_b = 16'(b16);
         r16_in_op = 1'($urandom_range(0, 1)); r16_in_sat = 1'($urandom_range(0, 1));
         r8_in_a = 8'(a8); r8_in_b = 8'(b8);
         r8_in_op = 1'($urandom_range(0, 1)); r8_in_sat = 1'($urandom_range(0, 1));
         apply_stimulus(25'(ma), 25'(mb), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         #1;
         check_output(1, 16, r_in_valid && r16_in_ready, a16, b16, r16_in_op, r16_in_sat,
                      r16_out_valid && r_out_ready, 64'(r16_out_sum), r16_out_ovf, r16_out_cout, "r16");
         check_output(2, 8, r_in_valid && r8_in_ready, a8, b8, r8_in_op, r8_in_sat,
                      r8_out_valid && r_out_ready, 64'(r8_out_sum), r8_out_ovf, r8_out_cout, "r8");
         check_output(0, 25, m_in_valid && m_in_ready, ma, mb, m_in_op, m_in_sat,
                      m_out_valid && m_out_ready, 64'(m_out_sum), m_out_ovf, m_out_cout, "r25");
         tick();
      end
      r_in_valid  = 1'b0;
      r_out_ready = 1'b1;
      m_in_valid  = 1'b0;
      m_out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         check_output(1, 16, 1'b0, 0, 0, 1'b0, 1'b0, r16_out_valid, 64'(r16_out_sum),
                      r16_out_ovf, r16_out_cout, "r16");
         check_output(2, 8, 1'b0, 0, 0, 1'b0, 1'b0, r8_out_valid, 64'(r8_out_sum),
                      r8_out_ovf, r8_out_cout, "r8");
         check_output(0, 25, 1'b0, 0, 0, 1'b0, 1'b0, m_out_valid, 64'(m_out_sum),
                      m_out_ovf, m_out_cout, "r25");
         tick();
      end
      check("r16_leftover", 64'(q16.size()), 64'd0);
      check("r8_leftover", 64'(q8.size()), 64'd0);
      check("r25_leftover", 64'(q25.size()), 64'd0);

      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
